onehot_rr_arbiter_64: RTL
=========================

Name: onehot_rr_arbiter_64

Overview:
- Round-robin arbiter over 64 request lines. Produces a registered, strictly one-hot grant vector with a valid/ready handshake.
- Sits directly upstream of the 64-to-6 one-hot encoder. The encoder turns grant_onehot into the 6-bit index of the selected lane/generator.
- Guarantees the encoder only ever sees a zero vector or exactly one set bit.

Parameters:
- N, 64, number of request lanes. Must match the encoder input width; only 64 is supported.
- IDXW, 6, pointer width, equal to log2(N).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- req  input  N  level requests, one per lane; a requester deasserts after it sees its grant accepted
- grant_ready  input  1  downstream accepts the current grant on a rising edge where grant_valid=1 and grant_ready=1
- grant_valid  output  1  grant_onehot holds a valid grant
- grant_onehot  output  N  one-hot grant, fed to the encoder input
- rr_ptr  output  IDXW  current round-robin search start index (debug/verification)

Behaviour:
- Reset: synchronous, active-low (rst_n=0 sampled on a clk edge).
  - Reset values: grant_valid=0, grant_onehot=0, rr_ptr=0, state=IDLE.
  - Reset dominates every other event in the same cycle.
- Winner search (combinational):
  - Scan req from index rr_ptr upward, wrapping 63 -> 0, and take the first set bit.
  - If req is all zero, there is no winner.
- All outputs are registered; grant_onehot has no combinational path from req.
- States: IDLE, HOLD.
- IDLE (grant_valid=0, grant_onehot=0):
  - If a winner W exists: next edge sets grant_onehot=1<<W, grant_valid=1, state=HOLD.
  - Latency is 1 cycle from req sampled to grant visible.
  - If no winner: remain in IDLE.
- HOLD (grant_valid=1):
  - grant_onehot and rr_ptr are frozen while grant_ready=0. Changes on req are ignored; a grant is never withdrawn or replaced before acceptance.
  - On an accept edge (grant_ready=1), rr_ptr <= (W+1) mod 64, with 63 wrapping to 0.
  - Back-to-back grants: on the same accept edge, the search is re-run on the current req, starting from (W+1) mod 64.
    - If a winner W2 exists: grant_onehot=1<<W2 and grant_valid stays 1, giving one grant per cycle under continuous ready.
    - If no winner: grant_valid=0, grant_onehot=0, state=IDLE.
  - The lane just granted may win again only if it is the sole active request (wrap-around search reaches it last).
- grant_ready while grant_valid=0 is ignored and has no effect on rr_ptr.
- Invariant: popcount(grant_onehot) is 0 when grant_valid=0 and 1 when grant_valid=1. This holds on every cycle, including the first cycle after reset.
- Fairness: with K lanes continuously requesting and ready held at 1, each lane is granted exactly once per K consecutive grants.
- Reset mid-HOLD: the pending grant is discarded and no accept is recorded (rr_ptr=0).

Test Plan:
- Reset and first grant:
  - Hold rst_n=0 for 3 edges with req=all ones -> grant_valid=0, grant_onehot=0, rr_ptr=0 throughout.
  - Release reset -> the next edge gives grant_onehot=0x1, grant_valid=1.
- Rotation: req bits {5,40} held, grant_ready=1 continuously -> grants alternate 1<<5, 1<<40, 1<<5, 1<<40 on consecutive cycles; grant_valid stays 1.
- Backpressure:
  - Grant to lane 7 with grant_ready=0 for 4 cycles, while req changes to {3,50} -> grant_onehot stays 1<<7 and rr_ptr stays unchanged.
  - Assert grant_ready -> rr_ptr=8 and the next grant is 1<<50.
- Wrap-around: lane 63 granted and accepted with req={2,63} -> rr_ptr=0 and the next grant is 1<<2.
- Drain to idle: single req bit 10; the requester drops req in the accept cycle -> next edge gives grant_valid=0, grant_onehot=0, rr_ptr=11, state IDLE.
- Reset mid-HOLD: rst_n=0 while holding grant 1<<33 with grant_ready=1 in the same cycle -> next edge gives grant_valid=0, grant_onehot=0, rr_ptr=0.

Source files
------------

// File: rtl/onehot_rr_arbiter_64.sv
// Round-robin arbiter over 64 level requests with a registered, strictly one-hot
// grant and a valid/ready handshake; feeds the 64-to-6 one-hot encoder.
module onehot_rr_arbiter_64 #(
    parameter int unsigned N    = 64,
    parameter int unsigned IDXW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            grant_ready,
    output logic            grant_valid,
    output logic [N-1:0]    grant_onehot,
    output logic [IDXW-1:0] rr_ptr
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q,        state_d;
    logic              grant_valid_q,  grant_valid_d;
    logic [N-1:0]      grant_onehot_q, grant_onehot_d;
    logic [IDXW-1:0]   grant_idx_q,    grant_idx_d;
    logic [IDXW-1:0]   rr_ptr_q,       rr_ptr_d;

    logic              accept;
    logic [IDXW-1:0]   search_start;
    logic [N-1:0]      rotated;
    logic              found;
    logic [IDXW-1:0]   offset;
    logic [IDXW-1:0]   winner;

    assign accept = (state_q == HOLD) && grant_ready;

    // On an accept edge the search restarts just past the lane being retired.
    always_comb begin
        search_start = rr_ptr_q;
        if (accept) begin
            search_start = IDXW'(grant_idx_q + IDXW'(1));
        end
        rotated = N'({req, req} >> search_start);
        found   = 1'b0;
        offset  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = IDXW'(i);
            end
        end
        winner = IDXW'(search_start + offset);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        grant_valid_d  = grant_valid_q;
        grant_onehot_d = grant_onehot_q;
        grant_idx_d    = grant_idx_q;
        rr_ptr_d       = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = HOLD;
                    grant_valid_d  = 1'b1;
                    grant_onehot_d = N'(1) << winner;
                    grant_idx_d    = winner;
                end
            end
            HOLD: begin
                if (grant_ready) begin
                    rr_ptr_d = IDXW'(grant_idx_q + IDXW'(1));
                    if (found) begin
                        grant_onehot_d = N'(1) << winner;
                        grant_idx_d    = winner;
                    end else begin
                        state_d        = IDLE;
                        grant_valid_d  = 1'b0;
                        grant_onehot_d = '0;
                    end
                end
            end
            default: begin
                state_d        = IDLE;
                grant_valid_d  = 1'b0;
                grant_onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            grant_idx_q    <= '0;
            rr_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            grant_valid_q  <= grant_valid_d;
            grant_onehot_q <= grant_onehot_d;
            grant_idx_q    <= grant_idx_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_onehot = grant_onehot_q;
    assign rr_ptr       = rr_ptr_q;

endmodule
